axis_packet_splitter_mc: RTL and testbench
==========================================

Name: axis_packet_splitter_mc

Overview:
Multi-channel successor to the single-output AXI-Stream packet splitter. Accepts one input stream and cuts it into packets of a programmable beat count, with optional total-packet limit. Routes consecutive packets round-robin across M_COUNT output streams, driving tlast on each packet's final beat. Sits between a DMA/read stream and parallel KAN compute lanes.

Parameters:
DATA_WIDTH, 16, tdata width in bits
KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep
KEEP_WIDTH, KEEP_ENABLE ? (DATA_WIDTH+7)/8 : 1, tkeep width
ID_ENABLE, 0, propagate tid; ID_WIDTH, ID_ENABLE?8:1
USER_ENABLE, 0, propagate tuser; USER_WIDTH, USER_ENABLE?8:1
M_COUNT, 4, number of output streams (>=1)
PCKT_WIDTH, 32, beat-count width
CNT_WIDTH, 16, packet-count width
ALLOW_LOCKS, 1, honour lock input
IGNORE_TLAST, 0, 1 = input tlast ignored; end only on packet limit
RAISE_NON_DIVISIBLE, !IGNORE_TLAST, 1 = input tlast mid-packet -> error

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
operation_start  in  1  start request, sampled in IDLE/END
pckt_size  in  PCKT_WIDTH  beats per packet, latched at start
pckt_count  in  CNT_WIDTH  packets to emit, latched at start; 0 = unlimited
lock  in  1  freeze intake (if ALLOW_LOCKS)
external_error  in  1  force ERR
operation_busy  out  1  high in OPE
operation_complete  out  1  high in END
operation_error  out  1  one-cycle pulse on entry to ERR
transmission  out  1  registered: any m_axis handshake last cycle
pckt_index  out  CNT_WIDTH  packets fully accepted in this operation
s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tuser  in/out  std  input stream
m_axis_tdata  out  M_COUNT*DATA_WIDTH; m_axis_tkeep  out  M_COUNT*KEEP_WIDTH; m_axis_tvalid/tready/tlast  out/in/out  M_COUNT; m_axis_tid/tuser  out  M_COUNT*ID/USER_WIDTH; m_axis_tdest  out  M_COUNT*clog2(M_COUNT) = channel index

Behaviour:
- rst: state IDLE, all flags 0, counters 0, channel pointer 0, output register emptied (buffered beat discarded), all m_axis_tvalid 0, s_axis_tready 0. Applies mid-operation identically.
- FSM IDLE->OPE on operation_start; if latched pckt_size==0 -> ERR instead. OPE->END on accepting last beat of packet pckt_count (pckt_count!=0), or input tlast on a packet-final beat (!IGNORE_TLAST). OPE->ERR on input tlast at non-final beat when RAISE_NON_DIVISIBLE (else -> END, that beat gets tlast). END->OPE on start, else stays END. ERR->IDLE next cycle. external_error forces ERR from any state; rst has priority over all.
- s_axis_tready = busy && !lock_eff && output stage can accept. Beat counter increments on input handshake; at pckt_size-1 beat gets tlast, counter->0, pckt_index+1, channel pointer advances (M_COUNT-1 wraps to 0). pckt_index wraps at 2^CNT_WIDTH.
- Output stage: per-channel skid buffer (2 entries); input beat written to channel at pointer; only that channel's skid may block. Latency input->output 1 cycle; full throughput when downstream ready. Beats of packet N never reach channel other than N mod M_COUNT; order within channel preserved.
- lock (ALLOW_LOCKS=1): tready forced 0, FSM and counters hold; buffered beats still drain. lock ignored when ALLOW_LOCKS=0.
- END/ERR: intake stops; buffered beats still drain (not flushed except by rst).
- tdest per channel is constant channel index; tkeep/tid/tuser pass through.

Test Plan:
- M_COUNT=4, pckt_size=3, pckt_count=4, 12 beats data 0..11, all ready -> ch0:0,1,2 ch1:3..5 ch2:6..8 ch3:9..11, tlast on 2,5,8,11; complete high; pckt_index=4.
- pckt_size=4, pckt_count=0, input tlast on beat 7 -> two packets ch0/ch1, END; tlast on beat 6 instead -> operation_error pulse, IDLE.
- pckt_size=0 with start -> ERR one cycle, no tready ever asserted.
- ch1 tready held 0 for 10 cycles during packet 1 -> ch0 drains, input stalls after ch1 skid full (2 beats), no data lost/reordered.
- lock asserted 5 cycles mid-packet -> s_axis_tready 0, counters frozen, output continues draining; resumes same beat index.
- rst mid-packet, then new start pckt_size=2 -> first packet on ch0, pckt_index restarts at 0.

Source files
------------

// File: rtl/axis_packet_splitter_mc.sv
// axis_packet_splitter_mc
// Cuts one AXI-Stream input into packets of pckt_size beats, with an optional
// packet-count limit. Consecutive packets go round-robin to M_COUNT output
// streams, and tlast is driven on each packet's final beat.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   operation_start            start request (accepted in IDLE/END)
//   pckt_size, pckt_count      beats per packet / packet limit (0 = unlimited), latched at start
//   lock, external_error       intake freeze / forced error
//   operation_busy/complete    high in OPE / END
//   operation_error            one-cycle pulse on entry to ERR
//   transmission               any output handshake in the previous cycle
//   pckt_index                 packets closed in the current operation
//   s_axis_*                   input stream
//   m_axis_*                   M_COUNT output streams, flattened; tdest = channel index
module axis_packet_splitter_mc #(
  parameter int DATA_WIDTH          = 16,
  parameter int KEEP_ENABLE         = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH          = (KEEP_ENABLE != 0) ? (DATA_WIDTH + 7) / 8 : 1,
  parameter int ID_ENABLE           = 0,
  parameter int ID_WIDTH            = (ID_ENABLE != 0) ? 8 : 1,
  parameter int USER_ENABLE         = 0,
  parameter int USER_WIDTH          = (USER_ENABLE != 0) ? 8 : 1,
  parameter int M_COUNT             = 4,
  parameter int PCKT_WIDTH          = 32,
  parameter int CNT_WIDTH           = 16,
  parameter int ALLOW_LOCKS         = 1,
  parameter int IGNORE_TLAST        = 0,
  parameter int RAISE_NON_DIVISIBLE = (IGNORE_TLAST == 0),
  localparam int DEST_WIDTH         = (M_COUNT > 1) ? $clog2(M_COUNT) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           operation_start,
  input  logic [PCKT_WIDTH-1:0]          pckt_size,
  input  logic [CNT_WIDTH-1:0]           pckt_count,
  input  logic                           lock,
  input  logic                           external_error,
  output logic                           operation_busy,
  output logic                           operation_complete,
  output logic                           operation_error,
  output logic                           transmission,
  output logic [CNT_WIDTH-1:0]           pckt_index,
  input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]          s_axis_tkeep,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  input  logic [ID_WIDTH-1:0]            s_axis_tid,
  input  logic [USER_WIDTH-1:0]          s_axis_tuser,
  output logic [M_COUNT*DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0]  m_axis_tkeep,
  output logic [M_COUNT-1:0]             m_axis_tvalid,
  input  logic [M_COUNT-1:0]             m_axis_tready,
  output logic [M_COUNT-1:0]             m_axis_tlast,
  output logic [M_COUNT*ID_WIDTH-1:0]    m_axis_tid,
  output logic [M_COUNT*USER_WIDTH-1:0]  m_axis_tuser,
  output logic [M_COUNT*DEST_WIDTH-1:0]  m_axis_tdest
);

  localparam int BW = DATA_WIDTH + KEEP_WIDTH + ID_WIDTH + USER_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_OPE, S_END, S_ERR} state_t;
  state_t state, state_next;

  logic [PCKT_WIDTH-1:0] size_q, beat_cnt;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [DEST_WIDTH-1:0] ch_ptr;
  logic [M_COUNT-1:0]    ch_full;
  logic                  lock_eff, start_ok, s_hs;
  logic                  in_last, beat_final, pkt_close, limit_hit;
  logic [BW-1:0]         in_beat;

  assign lock_eff   = (ALLOW_LOCKS != 0) && lock;
  assign start_ok   = operation_start && (state == S_IDLE || state == S_END);
  assign s_hs       = s_axis_tvalid && s_axis_tready;
  assign in_last    = (IGNORE_TLAST == 0) && s_axis_tlast;
  assign beat_final = (beat_cnt == size_q - PCKT_WIDTH'(1));
  assign pkt_close  = beat_final || in_last;
  assign limit_hit  = (count_q != '0) && (pckt_index == count_q - CNT_WIDTH'(1));

  // Only the channel currently being filled can stall the input.
  assign s_axis_tready = (state == S_OPE) && !lock_eff && !ch_full[ch_ptr];

  assign operation_busy     = (state == S_OPE);
  assign operation_complete = (state == S_END);

  assign in_beat = {pkt_close,
                    (USER_ENABLE != 0) ? s_axis_tuser : '0,
                    (ID_ENABLE   != 0) ? s_axis_tid   : '0,
                    (KEEP_ENABLE != 0) ? s_axis_tkeep : '1,
                    s_axis_tdata};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_END: begin
        if (operation_start) state_next = (pckt_size == '0) ? S_ERR : S_OPE;
      end
      S_OPE: begin
        if (s_hs) begin
          if (beat_final) begin
            if (limit_hit || in_last) state_next = S_END;
          end else if (in_last) begin
            state_next = (RAISE_NON_DIVISIBLE != 0) ? S_ERR : S_END;
          end
        end
      end
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (external_error) state_next = S_ERR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      size_q          <= '0;
      count_q         <= '0;
      beat_cnt        <= '0;
      pckt_index      <= '0;
      ch_ptr          <= '0;
      operation_error <= 1'b0;
      transmission    <= 1'b0;
    end else begin
      operation_error <= (state_next == S_ERR) && (state != S_ERR);
      transmission    <= |(m_axis_tvalid & m_axis_tready);
      if (start_ok) begin
        size_q     <= pckt_size;
        count_q    <= pckt_count;
        beat_cnt   <= '0;
        pckt_index <= '0;
        ch_ptr     <= '0;
      end else if (s_hs) begin
        if (pkt_close) begin
          beat_cnt   <= '0;
          pckt_index <= pckt_index + CNT_WIDTH'(1);
          ch_ptr     <= (ch_ptr == DEST_WIDTH'(M_COUNT - 1)) ? '0 : ch_ptr + DEST_WIDTH'(1);
        end else begin
          beat_cnt <= beat_cnt + PCKT_WIDTH'(1);
        end
      end
    end
  end

  for (genvar c = 0; c < M_COUNT; c++) begin : g_ch
    logic [BW-1:0] head, tail;
    logic [1:0]    fill;
    logic          push, pop;

    assign push       = s_hs && (ch_ptr == DEST_WIDTH'(c));
    assign pop        = (fill != 2'd0) && m_axis_tready[c];
    assign ch_full[c] = (fill == 2'd2);

    // Two-entry skid: head feeds the output, tail catches a beat while the
    // head is stalled. Push is never offered while full, so push+pop only
    // happens with a single entry present.
    always_ff @(posedge clk) begin
      if (rst) begin
        fill <= 2'd0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (fill == 2'd0) head <= in_beat;
            else              tail <= in_beat;
            fill <= fill + 2'd1;
          end
          2'b01: begin
            head <= tail;
            fill <= fill - 2'd1;
          end
          2'b11:   head <= in_beat;
          default: ;
        endcase
      end
    end

    assign m_axis_tvalid[c] = (fill != 2'd0);
    assign m_axis_tlast[c]  = head[BW-1];
    assign m_axis_tdata[c*DATA_WIDTH +: DATA_WIDTH] = head[DATA_WIDTH-1:0];
    assign m_axis_tkeep[c*KEEP_WIDTH +: KEEP_WIDTH] = head[DATA_WIDTH +: KEEP_WIDTH];
    assign m_axis_tid[c*ID_WIDTH +: ID_WIDTH]       = head[DATA_WIDTH+KEEP_WIDTH +: ID_WIDTH];
    assign m_axis_tuser[c*USER_WIDTH +: USER_WIDTH] = head[DATA_WIDTH+KEEP_WIDTH+ID_WIDTH +: USER_WIDTH];
    assign m_axis_tdest[c*DEST_WIDTH +: DEST_WIDTH] = DEST_WIDTH'(c);
  end

endmodule

// File: tb/tb_axis_packet_splitter_mc.sv
module tb_axis_packet_splitter_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        operation_start = 1'b0;
  logic [31:0] pckt_size = '0;
  logic [15:0] pckt_count = '0;
  logic        lock = 1'b0;
  logic        external_error = 1'b0;
  logic        operation_busy, operation_complete, operation_error, transmission;
  logic [15:0] pckt_index;
  logic [15:0] s_axis_tdata = '0;
  logic [1:0]  s_axis_tkeep = 2'b11;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [0:0]  s_axis_tid = '0;
  logic [0:0]  s_axis_tuser = '0;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic [3:0]  m_axis_tvalid;
  logic [3:0]  m_axis_tready = 4'hF;
  logic [3:0]  m_axis_tlast;
  logic [3:0]  m_axis_tid, m_axis_tuser;
  logic [7:0]  m_axis_tdest;

  axis_packet_splitter_mc dut (
    .clk(clk), .rst(rst), .operation_start(operation_start),
    .pckt_size(pckt_size), .pckt_count(pckt_count), .lock(lock),
    .external_error(external_error), .operation_busy(operation_busy),
    .operation_complete(operation_complete), .operation_error(operation_error),
    .transmission(transmission), .pckt_index(pckt_index),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid), .m_axis_tuser(m_axis_tuser),
    .m_axis_tdest(m_axis_tdest)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic        last;
    logic [1:0]  keep;
    logic [15:0] data;
  } rec_t;

  rec_t recs[$];
  rec_t mon_r;
  int   acc_cnt = 0;
  bit   rdy_seen = 0;
  int   total = 0;
  int   bad = 0;

  // Inputs change at posedge+1, so at negedge every handshake of the next edge is settled.
  always @(negedge clk) begin
    if (s_axis_tvalid && s_axis_tready) acc_cnt++;
    if (s_axis_tready) rdy_seen = 1;
    for (int c = 0; c < 4; c++) begin
      if (m_axis_tvalid[c] && m_axis_tready[c]) begin
        mon_r.ch   = 2'(c);
        mon_r.last = m_axis_tlast[c];
        mon_r.keep = m_axis_tkeep[c*2 +: 2];
        mon_r.data = m_axis_tdata[c*16 +: 16];
        recs.push_back(mon_r);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running need finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; operation_start = 1'b0; lock = 1'b0; external_error = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    step(); step();
    rst = 1'b0;
    recs.delete(); acc_cnt = 0;
  endtask

  task automatic start_op(input int size, input int count);
    pckt_size = 32'(size); pckt_count = 16'(count); operation_start = 1'b1;
    step();
    operation_start = 1'b0;
  endtask

  task automatic drive(input int base, input int n, input int last_idx, output bit timeout);
    timeout = 0;
    for (int i = 0; i < n; i++) begin
      int budget;
      budget = 0;
      s_axis_tdata = 16'(base + i); s_axis_tlast = (i == last_idx); s_axis_tvalid = 1'b1;
      forever begin
        @(negedge clk);
        if (s_axis_tready) break;
        budget++;
        if (budget > 200) begin timeout = 1; break; end
      end
      if (timeout) break;
      step();
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
    total++; if (operation_busy !== 1'b0 || operation_complete !== 1'b0 || operation_error !== 1'b0) begin bad++;
      $display("FAIL reset_flags: got busy=%b complete=%b error=%b need 0 0 0", operation_busy, operation_complete, operation_error); end
    total++; if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL reset_tready: got %b need 0", s_axis_tready); end
    total++; if (m_axis_tvalid !== 4'h0) begin bad++; $display("FAIL reset_mvalid: got %h need 0", m_axis_tvalid); end
    total++; if (pckt_index !== 16'd0 || transmission !== 1'b0) begin bad++;
      $display("FAIL reset_index: got index=%0d trans=%b need 0 0", pckt_index, transmission); end
  endtask

  task automatic test_basic();
    bit to;
    do_reset();
    m_axis_tready = 4'hF; s_axis_tkeep = 2'b10;
    start_op(3, 4);
    drive(0, 12, -1, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL basic_timeout: got stalled need flowing"); end
    total++; if (operation_complete !== 1'b1 || operation_busy !== 1'b0) begin bad++;
      $display("FAIL basic_end: got complete=%b busy=%b need 1 0", operation_complete, operation_busy); end
    total++; if (pckt_index !== 16'd4) begin bad++; $display("FAIL basic_index: got %0d need 4", pckt_index); end
    total++; if (transmission !== 1'b1) begin bad++; $display("FAIL basic_trans_on: got %b need 1", transmission); end
    repeat (4) step();
    total++; if (transmission !== 1'b0 || m_axis_tvalid !== 4'h0 || s_axis_tready !== 1'b0) begin bad++;
      $display("FAIL basic_idle: got trans=%b mvalid=%h tready=%b need 0 0 0", transmission, m_axis_tvalid, s_axis_tready); end
    total++; if (m_axis_tdest !== 8'hE4) begin bad++; $display("FAIL basic_tdest: got %h need e4", m_axis_tdest); end
    total++; if (recs.size() !== 12) begin bad++; $display("FAIL basic_count: got %0d need 12", recs.size()); end
    for (int i = 0; i < recs.size() && i < 12; i++) begin
      total++;
      if (recs[i].data !== 16'(i) || recs[i].ch !== 2'((i / 3) % 4) || recs[i].last !== (i % 3 == 2) || recs[i].keep !== 2'b10) begin
        bad++;
        $display("FAIL basic_beat%0d: got ch=%0d data=%0d last=%b keep=%b need ch=%0d data=%0d last=%b keep=10",
                 i, recs[i].ch, recs[i].data, recs[i].last, recs[i].keep, (i / 3) % 4, i, (i % 3 == 2));
      end
    end
    s_axis_tkeep = 2'b11;
  endtask

  task automatic test_tlast_end();
    bit to;
    recs.delete();
    start_op(4, 0);
    drive(100, 8, 7, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL tlast_timeout: got stalled need flowing"); end
    total++; if (operation_complete !== 1'b1 || pckt_index !== 16'd2) begin bad++;
      $display("FAIL tlast_end: got complete=%b index=%0d need 1 2", operation_complete, pckt_index); end
    repeat (4) step();
    total++; if (recs.size() !== 8) begin bad++; $display("FAIL tlast_count: got %0d need 8", recs.size()); end
    for (int i = 0; i < recs.size() && i < 8; i++) begin
      total++;
      if (recs[i].data !== 16'(100 + i) || recs[i].ch !== 2'(i / 4) || recs[i].last !== (i % 4 == 3)) begin
        bad++;
        $display("FAIL tlast_beat%0d: got ch=%0d data=%0d last=%b need ch=%0d data=%0d last=%b",
                 i, recs[i].ch, recs[i].data, recs[i].last, i / 4, 100 + i, (i % 4 == 3));
      end
    end
  endtask

  task automatic test_non_divisible();
    bit to;
    do_reset();
    start_op(4, 0);
    drive(150, 7, 6, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL nondiv_timeout: got stalled need flowing"); end
    total++; if (operation_error !== 1'b1 || operation_busy !== 1'b0) begin bad++;
      $display("FAIL nondiv_pulse: got error=%b busy=%b need 1 0", operation_error, operation_busy); end
    step();
    total++; if (operation_error !== 1'b0 || operation_busy !== 1'b0 || operation_complete !== 1'b0) begin bad++;
      $display("FAIL nondiv_idle: got error=%b busy=%b complete=%b need 0 0 0", operation_error, operation_busy, operation_complete); end
    repeat (3) step();
    total++; if (recs.size() !== 7) begin bad++; $display("FAIL nondiv_count: got %0d need 7", recs.size()); end
    for (int i = 0; i < recs.size() && i < 7; i++) begin
      total++;
      if (recs[i].data !== 16'(150 + i) || recs[i].ch !== 2'(i / 4) || (i < 6 && recs[i].last !== (i == 3))) begin
        bad++;
        $display("FAIL nondiv_beat%0d: got ch=%0d data=%0d last=%b need ch=%0d data=%0d",
                 i, recs[i].ch, recs[i].data, recs[i].last, i / 4, 150 + i);
      end
    end
  endtask

  task automatic test_zero_size();
    do_reset();
    rdy_seen = 0;
    s_axis_tvalid = 1'b1;
    start_op(0, 0);
    total++; if (operation_error !== 1'b1 || operation_busy !== 1'b0) begin bad++;
      $display("FAIL zero_err: got error=%b busy=%b need 1 0", operation_error, operation_busy); end
    step();
    total++; if (operation_error !== 1'b0 || operation_busy !== 1'b0 || operation_complete !== 1'b0) begin bad++;
      $display("FAIL zero_idle: got error=%b busy=%b complete=%b need 0 0 0", operation_error, operation_busy, operation_complete); end
    repeat (3) step();
    total++; if (rdy_seen !== 1'b0 || acc_cnt !== 0) begin bad++;
      $display("FAIL zero_tready: got seen=%b accepted=%0d need 0 0", rdy_seen, acc_cnt); end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic test_backpressure();
    bit to;
    do_reset();
    m_axis_tready = 4'b1101;
    start_op(3, 2);
    fork
      drive(200, 6, -1, to);
      begin
        repeat (10) step();
        total++; if (acc_cnt !== 5 || s_axis_tready !== 1'b0) begin bad++;
          $display("FAIL bp_stall: got accepted=%0d tready=%b need 5 0", acc_cnt, s_axis_tready); end
        total++; if (recs.size() !== 3 || m_axis_tvalid[1] !== 1'b1) begin bad++;
          $display("FAIL bp_drain: got out=%0d ch1valid=%b need 3 1", recs.size(), m_axis_tvalid[1]); end
        m_axis_tready = 4'hF;
      end
    join
    total++; if (to !== 1'b0 || operation_complete !== 1'b1) begin bad++;
      $display("FAIL bp_end: got timeout=%b complete=%b need 0 1", to, operation_complete); end
    repeat (4) step();
    total++; if (recs.size() !== 6) begin bad++; $display("FAIL bp_count: got %0d need 6", recs.size()); end
    for (int i = 0; i < recs.size() && i < 6; i++) begin
      total++;
      if (recs[i].data !== 16'(200 + i) || recs[i].ch !== 2'(i / 3) || recs[i].last !== (i % 3 == 2)) begin
        bad++;
        $display("FAIL bp_beat%0d: got ch=%0d data=%0d last=%b need ch=%0d data=%0d last=%b",
                 i, recs[i].ch, recs[i].data, recs[i].last, i / 3, 200 + i, (i % 3 == 2));
      end
    end
  endtask

  task automatic test_lock();
    bit to;
    do_reset();
    m_axis_tready = 4'hF;
    start_op(4, 1);
    fork
      drive(300, 4, -1, to);
      begin
        repeat (2) step();
        lock = 1'b1;
        step();
        total++; if (s_axis_tready !== 1'b0 || acc_cnt !== 2 || recs.size() !== 2) begin bad++;
          $display("FAIL lock_hold: got tready=%b accepted=%0d out=%0d need 0 2 2", s_axis_tready, acc_cnt, recs.size()); end
        repeat (4) step();
        total++; if (acc_cnt !== 2 || pckt_index !== 16'd0 || operation_busy !== 1'b1 || m_axis_tvalid !== 4'h0) begin bad++;
          $display("FAIL lock_frozen: got accepted=%0d index=%0d busy=%b mvalid=%h need 2 0 1 0",
                   acc_cnt, pckt_index, operation_busy, m_axis_tvalid); end
        lock = 1'b0;
      end
    join
    total++; if (to !== 1'b0 || operation_complete !== 1'b1 || pckt_index !== 16'd1) begin bad++;
      $display("FAIL lock_end: got timeout=%b complete=%b index=%0d need 0 1 1", to, operation_complete, pckt_index); end
    repeat (3) step();
    total++; if (recs.size() !== 4) begin bad++; $display("FAIL lock_count: got %0d need 4", recs.size()); end
    for (int i = 0; i < recs.size() && i < 4; i++) begin
      total++;
      if (recs[i].data !== 16'(300 + i) || recs[i].ch !== 2'd0 || recs[i].last !== (i == 3)) begin
        bad++;
        $display("FAIL lock_beat%0d: got ch=%0d data=%0d last=%b need ch=0 data=%0d last=%b",
                 i, recs[i].ch, recs[i].data, recs[i].last, 300 + i, (i == 3));
      end
    end
  endtask

  task automatic test_external_error();
    bit to;
    do_reset();
    start_op(4, 0);
    drive(350, 1, -1, to);
    external_error = 1'b1;
    step();
    external_error = 1'b0;
    total++; if (to !== 1'b0 || operation_error !== 1'b1 || operation_busy !== 1'b0) begin bad++;
      $display("FAIL exterr_pulse: got timeout=%b error=%b busy=%b need 0 1 0", to, operation_error, operation_busy); end
    step();
    total++; if (operation_error !== 1'b0 || operation_busy !== 1'b0 || operation_complete !== 1'b0) begin bad++;
      $display("FAIL exterr_idle: got error=%b busy=%b complete=%b need 0 0 0", operation_error, operation_busy, operation_complete); end
    total++; if (recs.size() !== 1 || recs[0].data !== 16'd350) begin bad++;
      $display("FAIL exterr_drain: got out=%0d need 1 beat of 350", recs.size()); end
  endtask

  task automatic test_rst_mid();
    bit to;
    do_reset();
    m_axis_tready = 4'b1101;
    start_op(3, 0);
    drive(400, 4, -1, to);
    total++; if (to !== 1'b0 || pckt_index !== 16'd1 || m_axis_tvalid[1] !== 1'b1) begin bad++;
      $display("FAIL rstmid_pre: got timeout=%b index=%0d ch1valid=%b need 0 1 1", to, pckt_index, m_axis_tvalid[1]); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (m_axis_tvalid !== 4'h0 || s_axis_tready !== 1'b0 || pckt_index !== 16'd0 || operation_busy !== 1'b0) begin bad++;
      $display("FAIL rstmid_clear: got mvalid=%h tready=%b index=%0d busy=%b need 0 0 0 0",
               m_axis_tvalid, s_axis_tready, pckt_index, operation_busy); end
    m_axis_tready = 4'hF;
    step();
    recs.delete();
    start_op(2, 1);
    drive(500, 2, -1, to);
    total++; if (to !== 1'b0 || operation_complete !== 1'b1 || pckt_index !== 16'd1) begin bad++;
      $display("FAIL rstmid_end: got timeout=%b complete=%b index=%0d need 0 1 1", to, operation_complete, pckt_index); end
    repeat (3) step();
    total++; if (recs.size() !== 2) begin bad++; $display("FAIL rstmid_count: got %0d need 2", recs.size()); end
    for (int i = 0; i < recs.size() && i < 2; i++) begin
      total++;
      if (recs[i].data !== 16'(500 + i) || recs[i].ch !== 2'd0 || recs[i].last !== (i == 1)) begin
        bad++;
        $display("FAIL rstmid_beat%0d: got ch=%0d data=%0d last=%b need ch=0 data=%0d last=%b",
                 i, recs[i].ch, recs[i].data, recs[i].last, 500 + i, (i == 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tlast_end();
    test_non_divisible();
    test_zero_size();
    test_backpressure();
    test_lock();
    test_external_error();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
